// File: rtl/rx_frame_controller.sv
// rx_frame_controller
//
// Receive-side UART frame sequencer. Detects the start-bit falling edge on the
// idle-high serial line, then walks the frame through START, DATA, optional
// PARITY and STOP using an oversample (edge) counter and a bit counter. At the
// oversample strobe point of each bit it issues a one-cycle enable to the
// matching datapath block, and at the end of the frame it qualifies the
// assembled byte with a one-cycle data_valid or frame_err pulse.
//
// Ports
//   CLK          oversampling clock
//   RST          synchronous, active-high reset
//   RX_IN        serial line, idle high
//   PAR_EN       frame carries a parity bit (latched at frame start)
//   PRESCALE     oversampling ratio, 8/16/32 (latched at frame start)
//   strt_glitch  start checker result, sampled at the end of the start bit
//   par_err      parity checker result, sampled at the end of the parity bit
//   stp_err      stop checker result, sampled at the end of the stop bit
//   dat_samp_en  sampler enable, high for the whole frame
//   strt_chk_en  one-cycle start checker strobe
//   par_chk_en   one-cycle parity checker strobe
//   stp_chk_en   one-cycle stop checker strobe
//   deser_en     one-cycle deserializer shift strobe, once per data bit
//   edge_cnt     oversample index within the current bit
//   bit_cnt      bit index within the frame (0 = start bit)
//   busy         frame in progress
//   data_valid   one-cycle pulse, deserializer byte is good
//   frame_err    one-cycle pulse, frame rejected
//
// Every output is a flop. The next-cycle value of each output is derived from
// the next-cycle state and counters, so strobes line up exactly with the
// edge_cnt value they are reported against.

module rx_frame_controller #(
    parameter int  DATA_WIDTH     = 8,
    parameter int  PRESCALE_WIDTH = 6,
    localparam int BIT_CNT_WIDTH  = $clog2(DATA_WIDTH + 3)
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic                      PAR_EN,
    input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
    input  logic                      strt_glitch,
    input  logic                      par_err,
    input  logic                      stp_err,
    output logic                      dat_samp_en,
    output logic                      strt_chk_en,
    output logic                      par_chk_en,
    output logic                      stp_chk_en,
    output logic                      deser_en,
    output logic [PRESCALE_WIDTH-1:0] edge_cnt,
    output logic [BIT_CNT_WIDTH-1:0]  bit_cnt,
    output logic                      busy,
    output logic                      data_valid,
    output logic                      frame_err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [PRESCALE_WIDTH-1:0] PS_ONE        = PRESCALE_WIDTH'(1);
    localparam logic [PRESCALE_WIDTH-1:0] PS_TWO        = PRESCALE_WIDTH'(2);
    localparam logic [BIT_CNT_WIDTH-1:0]  BC_ONE        = BIT_CNT_WIDTH'(1);
    localparam logic [BIT_CNT_WIDTH-1:0]  LAST_DATA_BIT = BIT_CNT_WIDTH'(DATA_WIDTH);

    state_t                      state_q;
    state_t                      state_d;
    logic [PRESCALE_WIDTH-1:0]   prescale_q;
    logic [PRESCALE_WIDTH-1:0]   prescale_d;
    logic                        par_en_q;
    logic                        par_en_d;
    logic                        sticky_q;
    logic                        sticky_d;
    logic [PRESCALE_WIDTH-1:0]   edge_d;
    logic [BIT_CNT_WIDTH-1:0]    bit_d;
    logic [PRESCALE_WIDTH-1:0]   end_pt;
    logic [PRESCALE_WIDTH-1:0]   strobe_pt_d;
    logic                        busy_d;
    logic                        at_strobe_d;
    logic                        data_valid_d;
    logic                        frame_err_d;

    // End-of-bit point for the latched ratio. For an illegal ratio the
    // subtraction simply wraps, so the counter still rolls over and cannot
    // lock up.
    assign end_pt = prescale_q - PS_ONE;

    // Next-state / next-counter logic
    always_comb begin
        state_d      = state_q;
        edge_d       = edge_cnt;
        bit_d        = bit_cnt;
        prescale_d   = prescale_q;
        par_en_d     = par_en_q;
        sticky_d     = sticky_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        if (state_q == IDLE) begin
            if (!RX_IN) begin
                state_d    = START;
                prescale_d = PRESCALE;
                par_en_d   = PAR_EN;
                sticky_d   = 1'b0;
                edge_d     = '0;
                bit_d      = '0;
            end
        end else if (edge_cnt == end_pt) begin
            edge_d = '0;
            bit_d  = bit_cnt + BC_ONE;
            case (state_q)
                START: begin
                    // A glitched start bit is dropped silently.
                    state_d = strt_glitch ? IDLE : DATA;
                end
                DATA: begin
                    // bit_cnt counts the start bit as 0, so the last data
                    // bit sits at index DATA_WIDTH.
                    if (bit_cnt == LAST_DATA_BIT) begin
                        state_d = par_en_q ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    sticky_d = sticky_q | par_err;
                    state_d  = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (!sticky_q && !stp_err) begin
                        data_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
            if (state_d == IDLE) begin
                edge_d = '0;
                bit_d  = '0;
            end
        end else begin
            edge_d = edge_cnt + PS_ONE;
        end
    end

    // Strobe point of the bit that will be current next cycle. Using the
    // next-cycle ratio makes the START strobe correct in the first frame
    // cycle, when the ratio is being latched.
    assign strobe_pt_d = prescale_d - PS_TWO;
    assign busy_d      = (state_d != IDLE);
    assign at_strobe_d = busy_d && (edge_d == strobe_pt_d);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            prescale_q  <= '0;
            par_en_q    <= 1'b0;
            sticky_q    <= 1'b0;
            edge_cnt    <= '0;
            bit_cnt     <= '0;
            dat_samp_en <= 1'b0;
            busy        <= 1'b0;
            strt_chk_en <= 1'b0;
            deser_en    <= 1'b0;
            par_chk_en  <= 1'b0;
            stp_chk_en  <= 1'b0;
            data_valid  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            state_q     <= state_d;
            prescale_q  <= prescale_d;
            par_en_q    <= par_en_d;
            sticky_q    <= sticky_d;
            edge_cnt    <= edge_d;
            bit_cnt     <= bit_d;
            dat_samp_en <= busy_d;
            busy        <= busy_d;
            strt_chk_en <= at_strobe_d && (state_d == START);
            deser_en    <= at_strobe_d && (state_d == DATA);
            par_chk_en  <= at_strobe_d && (state_d == PARITY);
            stp_chk_en  <= at_strobe_d && (state_d == STOP);
            data_valid  <= data_valid_d;
            frame_err   <= frame_err_d;
        end
    end

endmodule

// File: tb/tb_rx_frame_controller.sv
// tb_rx_frame_controller
//
// Bench for rx_frame_controller. Outputs are sampled on the falling edge and
// inputs are driven right after sampling. Each frame cycle's expected output
// bundle is computed arithmetically from the frame's position (cycle k of the
// frame sits in bit k/P at oversample k%P); the frame length and final pulse
// come from a table record or from the frame rules for random frames.

module tb_rx_frame_controller;

    logic       CLK;
    logic       RST;
    logic       RX_IN;
    logic       PAR_EN;
    logic [5:0] PRESCALE;
    logic       strt_glitch;
    logic       par_err;
    logic       stp_err;
    logic       dat_samp_en;
    logic       strt_chk_en;
    logic       par_chk_en;
    logic       stp_chk_en;
    logic       deser_en;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       busy;
    logic       data_valid;
    logic       frame_err;

    int vectors;
    int miscompares;

    typedef struct {
        int p;
        bit par;
        bit glitch;
        bit perr;
        bit serr;
        bit chain;
        int exp_len;
        bit exp_dv;
        bit exp_fe;
    } vec_t;

    vec_t vecs[9];

    rx_frame_controller #(
        .DATA_WIDTH     (8),
        .PRESCALE_WIDTH (6)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_IN       (RX_IN),
        .PAR_EN      (PAR_EN),
        .PRESCALE    (PRESCALE),
        .strt_glitch (strt_glitch),
        .par_err     (par_err),
        .stp_err     (stp_err),
        .dat_samp_en (dat_samp_en),
        .strt_chk_en (strt_chk_en),
        .par_chk_en  (par_chk_en),
        .stp_chk_en  (stp_chk_en),
        .deser_en    (deser_en),
        .edge_cnt    (edge_cnt),
        .bit_cnt     (bit_cnt),
        .busy        (busy),
        .data_valid  (data_valid),
        .frame_err   (frame_err)
    );

    // Clock / reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    // Expected output bundle {samp, strt, deser, par, stp, edge[6], bit[4], busy, dv, fe}
    // for cycle k of a frame of len cycles at ratio p (k == len is the pulse cycle).
    function automatic logic [17:0] exp_bundle(input int k, input int p, input bit par,
                                               input int len, input bit dv, input bit fe);
        logic       samp, st, de, pc, sc, bz, edv, efe;
        logic [5:0] ec;
        logic [3:0] bc;
        int         nb;
        int         b;
        nb   = len / p;
        samp = 1'b0; st = 1'b0; de = 1'b0; pc = 1'b0; sc = 1'b0;
        bz   = 1'b0; edv = 1'b0; efe = 1'b0; ec = '0; bc = '0;
        if (k < len) begin
            b    = k / p;
            samp = 1'b1;
            bz   = 1'b1;
            ec   = 6'(k % p);
            bc   = 4'(b);
            if ((k % p) == p - 2) begin
                st = (b == 0);
                de = (b >= 1) && (b <= 8);
                pc = par && (b == 9) && (nb > 1);
                sc = (nb > 1) && (b == nb - 1);
            end
        end else if (k == len) begin
            edv = dv;
            efe = fe;
        end
        return {samp, st, de, pc, sc, ec, bc, bz, edv, efe};
    endfunction

    // Scoreboard compare
    task automatic check(input string name, input logic [17:0] exp);
        logic [17:0] act;
        act = {dat_samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en,
               edge_cnt, bit_cnt, busy, data_valid, frame_err};
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] rand_prescale();
        case ($urandom_range(0, 2))
            0:       return 6'd8;
            1:       return 6'd16;
            default: return 6'd32;
        endcase
    endfunction

    task automatic drive_noise();
        strt_glitch = 1'($urandom_range(0, 1));
        par_err     = 1'($urandom_range(0, 1));
        stp_err     = 1'($urandom_range(0, 1));
    endtask

    // Drive the inputs seen during frame cycle k. Checker results matter only
    // at the end of their own bit; everything else is noise.
    task automatic drive_cycle(input int k, input vec_t v);
        int e;
        int b;
        int nb;
        e  = k % v.p;
        b  = k / v.p;
        nb = v.exp_len / v.p;
        RX_IN    = 1'($urandom_range(0, 1));
        PRESCALE = rand_prescale();
        PAR_EN   = 1'($urandom_range(0, 1));
        drive_noise();
        if (e == v.p - 1) begin
            if (b == 0) strt_glitch = v.glitch;
            if (v.par && b == 9) par_err = v.perr;
            if (!v.glitch && b == nb - 1) stp_err = v.serr;
        end
    endtask

    // Called at a falling edge while the DUT is idle: starts a frame now and
    // checks every frame cycle plus the pulse cycle.
    task automatic run_frame(input string name, input vec_t v);
        PRESCALE = 6'(v.p);
        PAR_EN   = v.par;
        RX_IN    = 1'b0;
        drive_noise();
        for (int k = 0; k < v.exp_len; k++) begin
            @(negedge CLK);
            check(name, exp_bundle(k, v.p, v.par, v.exp_len, v.exp_dv, v.exp_fe));
            drive_cycle(k, v);
        end
        @(negedge CLK);
        check({name, "_end"}, exp_bundle(v.exp_len, v.p, v.par, v.exp_len, v.exp_dv, v.exp_fe));
        RX_IN = 1'b1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            RX_IN = 1'b1;
            drive_noise();
            @(negedge CLK);
            check("idle", 18'h0);
        end
    endtask

    initial begin
        vec_t r;
        vec_t ab;
        vectors     = 0;
        miscompares = 0;

        //            p  par gl pe se ch len  dv fe
        vecs[0] = '{ 8, 0, 0, 0, 0, 1,  80, 1, 0};
        vecs[1] = '{ 8, 1, 0, 0, 0, 0,  88, 1, 0};
        vecs[2] = '{16, 1, 0, 1, 0, 0, 176, 0, 1};
        vecs[3] = '{16, 0, 0, 0, 1, 0, 160, 0, 1};
        vecs[4] = '{ 8, 0, 1, 0, 0, 0,   8, 0, 0};
        vecs[5] = '{32, 0, 0, 0, 0, 0, 320, 1, 0};
        vecs[6] = '{32, 0, 0, 0, 0, 1, 320, 1, 0};
        vecs[7] = '{16, 0, 0, 1, 0, 0, 160, 1, 0};
        vecs[8] = '{32, 1, 0, 1, 1, 0, 352, 0, 1};

        // Reset held for two cycles with the line low
        RST      = 1'b1;
        RX_IN    = 1'b0;
        PAR_EN   = 1'b0;
        PRESCALE = 6'd8;
        drive_noise();
        @(negedge CLK);
        check("reset_1", 18'h0);
        @(negedge CLK);
        check("reset_2", 18'h0);
        RST = 1'b0;

        // Table: first entry starts right on reset release
        for (int i = 0; i < 9; i++) begin
            if (!vecs[i].chain) idle_cycles(3);
            run_frame("table", vecs[i]);
        end

        // Random frames against the frame rules
        for (int i = 0; i < 24; i++) begin
            r.p       = int'(rand_prescale());
            r.par     = 1'($urandom_range(0, 1));
            r.glitch  = ($urandom_range(0, 5) == 0);
            r.perr    = 1'($urandom_range(0, 1));
            r.serr    = ($urandom_range(0, 3) == 0);
            r.chain   = 1'($urandom_range(0, 1));
            r.exp_len = r.glitch ? r.p : r.p * (10 + int'(r.par));
            r.exp_dv  = !r.glitch && !(r.par && r.perr) && !r.serr;
            r.exp_fe  = !r.glitch && !r.exp_dv;
            if (!r.chain) idle_cycles(int'($urandom_range(1, 4)));
            run_frame("random", r);
        end

        // Reset during data bit 4 (bit_cnt 5), then a clean frame
        idle_cycles(2);
        ab = '{8, 0, 0, 0, 0, 0, 80, 1, 0};
        PRESCALE = 6'd8;
        PAR_EN   = 1'b0;
        RX_IN    = 1'b0;
        for (int k = 0; k <= 5 * 8 + 3; k++) begin
            @(negedge CLK);
            check("abort_frame", exp_bundle(k, 8, 1'b0, 80, 1'b1, 1'b0));
            drive_cycle(k, ab);
        end
        RST = 1'b1;
        @(negedge CLK);
        check("abort_reset", 18'h0);
        RST   = 1'b0;
        RX_IN = 1'b1;
        idle_cycles(3);
        run_frame("after_abort", ab);
        idle_cycles(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rx_frame_controller.md
# rx_frame_controller

Receive-side UART frame sequencer. It owns the oversampling edge counter and bit counter and walks each frame through start, data, optional parity and stop bits. It issues single-cycle enables to the sampler, deserializer, start/parity/stop checkers, and qualifies the assembled byte with a one-cycle `data_valid` or `frame_err` pulse. It sits between the RX pin and the receive datapath blocks (sampler, deserializer, parity/start/stop checkers), all of which run on the same `CLK`.

## Interface
- `DATA_WIDTH`, 8: data bits per frame.
- `PRESCALE_WIDTH`, 6: width of `PRESCALE` and `edge_cnt`.
- `CLK` input 1: single clock, oversampling rate.
- `RST` input 1: reset, synchronous and active-high.
- `RX_IN` input 1: serial line, idle high.
- `PAR_EN` input 1: 1 means the frame carries a parity bit.
- `PRESCALE` input PRESCALE_WIDTH: oversampling ratio; legal values are 8, 16 and 32.
- `strt_glitch` input 1: start checker result, registered.
- `par_err` input 1: parity checker result, registered.
- `stp_err` input 1: stop checker result, registered.
- `dat_samp_en` output 1: sampler enable.
- `strt_chk_en`, `par_chk_en`, `stp_chk_en` output 1 each: one-cycle checker strobes.
- `deser_en` output 1: one-cycle shift strobe to the deserializer.
- `edge_cnt` output PRESCALE_WIDTH: oversample index within the current bit.
- `bit_cnt` output $clog2(DATA_WIDTH+3): bit index within the frame.
- `busy` output 1: frame in progress.
- `data_valid` output 1: one-cycle pulse; the deserializer byte is good.
- `frame_err` output 1: one-cycle pulse; the frame was rejected.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Let P be the value of `PRESCALE` latched at frame start. Let S = P-2 (strobe point) and E = P-1 (end of bit).
- **IDLE**
  - On `RX_IN`=0: latch `PRESCALE` and `PAR_EN`, clear `edge_cnt`, `bit_cnt` and the sticky parity flag, then go to START.
  - `PRESCALE`/`PAR_EN` changes mid-frame are ignored.
- **All non-IDLE states**
  - `dat_samp_en`=1 and `busy`=1.
  - `edge_cnt` increments each cycle and wraps E→0. `bit_cnt` increments on the wrap.
- **START**
  - `strt_chk_en` pulses at `edge_cnt`==S.
  - At E: if `strt_glitch`=1, go to IDLE with no pulse on `data_valid` or `frame_err`; otherwise go to DATA.
- **DATA**
  - `deser_en` pulses at `edge_cnt`==S in each data bit.
  - At E of data bit DATA_WIDTH-1 (`bit_cnt`==DATA_WIDTH): go to PARITY if latched `PAR_EN`=1, else STOP.
- **PARITY**
  - `par_chk_en` pulses at S.
  - At E: OR `par_err` into the sticky flag, then go to STOP.
- **STOP**
  - `stp_chk_en` pulses at S.
  - At E, go to IDLE, and:
    - if the sticky flag is 0 and `stp_err` is 0, pulse `data_valid`;
    - otherwise pulse `frame_err`.
- Checker results are sampled only at E. Values at any other cycle are don't-care.
- `RST`=1 at any point, including mid-frame: the next state is IDLE and every output is 0 on the following edge. A partial frame produces no pulse.

## Timing
- Reset values: all outputs 0, `edge_cnt`=0, `bit_cnt`=0, state IDLE.
- All outputs are registered. Each strobe is high for exactly one cycle per bit.
- Start detect: `RX_IN` falling in cycle t means START with `edge_cnt`=0 in cycle t+1.
- Frame length in START..STOP cycles: P·(DATA_WIDTH+2+PAR_EN). Examples: 80 at P=8 without parity, 88 with parity.
- Pulse timing: `data_valid`/`frame_err` is high on the first IDLE cycle after STOP ends. It never coincides with a strobe.
- Back-to-back frames: `RX_IN`=0 seen during that first IDLE cycle starts the next frame immediately. This costs at most 1 oversample of slip.
- `RX_IN` is ignored outside IDLE. Line noise mid-frame is handled only through the checker results.
- Illegal `PRESCALE` values give undefined sampling. Counters must still wrap at E and never lock up.

## Test plan
- Reset: assert `RST` for 2 cycles with `RX_IN`=0 → all outputs 0; START entered on the first cycle after release.
- P=8, `PAR_EN`=0, byte 0xA5 LSB-first, good stop bit → 8 `deser_en` pulses at `edge_cnt`==6; `data_valid` pulses exactly 80 cycles after START entry; `frame_err` stays 0.
- P=16, `PAR_EN`=1, `par_err`=1 at the parity E → `stp_chk_en` still pulses; `frame_err`=1 and `data_valid`=0 at frame end.
- Start glitch: `strt_glitch`=1 at START E → return to IDLE after P cycles; no `deser_en`, `data_valid` or `frame_err`.
- Two back-to-back frames at P=32 with zero idle between them → both produce `data_valid`; the second frame's START begins on the cycle after the first pulse.
- `RST` asserted during DATA bit 4 → state IDLE on the next edge, no pulse, `bit_cnt`=0; the next frame completes normally.
